arbitro_memoria: RTL and testbench

//  Sequencer in front of the single shared instruction/data memory (memoria, 1024 x 32-bit words).

---
 rtl/arbitro_memoria_pkg.sv | 19 +
 rtl/arbitro_memoria_if.sv | 35 +++
 rtl/arbitro_memoria_verificador.sv | 16 +
 rtl/arbitro_memoria.sv | 155 +++++++++++++++
 tb/tb_arbitro_memoria.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_memoria_pkg.sv
// Shared definitions for the instruction/data memory sequencer: FSM encodings,
// memory geometry and the per-access record latched at grant time.
package arbitro_memoria_pkg;

  localparam int PALAVRAS_PADRAO = 1024;
  localparam int DESLOC_PALAVRA  = 2;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] PREPARA  = 2'd1;
  localparam logic [1:0] ACESSO   = 2'd2;
  localparam logic [1:0] RECUPERA = 2'd3;

  typedef struct packed {
    logic dados;    // 1 = load/store port won, 0 = fetch port
    logic escrita;
    logic erro;
  } transacao_t;

endpackage

// File: rtl/arbitro_memoria_if.sv
// Requester and memoria-side signals of the sequencer, grouped in one bundle.
interface arbitro_memoria_if #(
  parameter int LARGURA = 32
);
  logic               busca_req;
  logic [LARGURA-1:0] busca_endereco;
  logic               busca_ack;
  logic [LARGURA-1:0] busca_dado;
  logic               dados_req;
  logic               dados_escrita;
  logic [LARGURA-1:0] dados_endereco;
  logic [LARGURA-1:0] dados_wdata;
  logic               dados_ack;
  logic [LARGURA-1:0] dados_rdata;
  logic               erro_endereco;
  logic [LARGURA-1:0] mem_endereco;
  logic [LARGURA-1:0] mem_dado_escrita;
  logic               mem_escrita;
  logic               mem_leitura;
  logic [LARGURA-1:0] mem_instrucao;

  modport slave (
    input  busca_req, busca_endereco, dados_req, dados_escrita, dados_endereco,
           dados_wdata, mem_instrucao,
    output busca_ack, busca_dado, dados_ack, dados_rdata, erro_endereco,
           mem_endereco, mem_dado_escrita, mem_escrita, mem_leitura
  );

  modport master (
    output busca_req, busca_endereco, dados_req, dados_escrita, dados_endereco,
           dados_wdata, mem_instrucao,
    input  busca_ack, busca_dado, dados_ack, dados_rdata, erro_endereco,
           mem_endereco, mem_dado_escrita, mem_escrita, mem_leitura
  );
endinterface

// File: rtl/arbitro_memoria_verificador.sv
// Byte address to word index conversion plus alignment / range check.
module verificador_endereco
  import arbitro_memoria_pkg::*;
#(
  parameter int LARGURA  = 32,
  parameter int PALAVRAS = PALAVRAS_PADRAO
) (
  input  logic [LARGURA-1:0] endereco_i,
  output logic [LARGURA-1:0] indice_o,
  output logic               erro_o
);

  assign indice_o = endereco_i >> DESLOC_PALAVRA;
  assign erro_o   = (endereco_i[1:0] != 2'b00) || (indice_o >= LARGURA'(PALAVRAS));

endmodule

// File: rtl/arbitro_memoria.sv
// Sequencer in front of memoria: arbitrates fetch vs load/store, holds one strobe
// for CICLOS_ACESSO cycles with an idle cycle on both sides, pulses the winner's ack.
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int LARGURA       = 32,
  parameter int PALAVRAS      = PALAVRAS_PADRAO,
  parameter int CICLOS_ACESSO = 2
) (
  input logic              clock,
  input logic              reset,
  arbitro_memoria_if.slave bus
);

  localparam int            CW     = (CICLOS_ACESSO > 1) ? $clog2(CICLOS_ACESSO) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(CICLOS_ACESSO - 1);

  logic [1:0]         estado_q, estado_d;
  logic [CW-1:0]      cont_q, cont_d;
  logic               prio_dados_q, prio_dados_d;
  transacao_t         trans_q, trans_d;
  logic [LARGURA-1:0] mem_end_q, mem_end_d;
  logic [LARGURA-1:0] mem_wd_q, mem_wd_d;
  logic [LARGURA-1:0] bdado_q, bdado_d;
  logic [LARGURA-1:0] rdata_q, rdata_d;
  logic               leit_q, leit_d;
  logic               esc_q, esc_d;
  logic               back_q, back_d;
  logic               dack_q, dack_d;
  logic               erro_q, erro_d;

  logic               venc_dados;
  logic               erro_chk;
  logic               conclui;
  logic [LARGURA-1:0] end_sel;
  logic [LARGURA-1:0] indice;
  logic [LARGURA-1:0] dado_lido;

  // dados wins unless both are pending and the last grant already went to dados
  assign venc_dados = bus.dados_req && (!bus.busca_req || prio_dados_q);
  assign end_sel    = venc_dados ? bus.dados_endereco : bus.busca_endereco;
  assign dado_lido  = trans_q.erro ? '0 : bus.mem_instrucao;

  verificador_endereco #(
    .LARGURA  (LARGURA),
    .PALAVRAS (PALAVRAS)
  ) u_verif (
    .endereco_i (end_sel),
    .indice_o   (indice),
    .erro_o     (erro_chk)
  );

  always_comb begin
    estado_d     = estado_q;
    cont_d       = cont_q;
    prio_dados_d = prio_dados_q;
    trans_d      = trans_q;
    mem_end_d    = mem_end_q;
    mem_wd_d     = mem_wd_q;
    bdado_d      = bdado_q;
    rdata_d      = rdata_q;
    leit_d       = leit_q;
    esc_d        = esc_q;
    back_d       = 1'b0;
    dack_d       = 1'b0;
    erro_d       = 1'b0;
    conclui      = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (bus.busca_req || bus.dados_req) begin
          estado_d        = PREPARA;
          prio_dados_d    = !venc_dados;
          trans_d.dados   = venc_dados;
          trans_d.escrita = venc_dados && bus.dados_escrita;
          trans_d.erro    = erro_chk;
          mem_end_d       = indice;
          mem_wd_d        = venc_dados ? bus.dados_wdata : '0;
        end
      end
      PREPARA: begin
        if (trans_q.erro) begin
          conclui = 1'b1;
        end else begin
          estado_d = ACESSO;
          cont_d   = '0;
          leit_d   = !trans_q.escrita;
          esc_d    = trans_q.escrita;
        end
      end
      ACESSO: begin
        if (cont_q == ULTIMO) conclui = 1'b1;
        else                  cont_d  = cont_q + CW'(1);
      end
      RECUPERA: estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase

    if (conclui) begin
      estado_d = RECUPERA;
      leit_d   = 1'b0;
      esc_d    = 1'b0;
      back_d   = !trans_q.dados;
      dack_d   = trans_q.dados;
      erro_d   = trans_q.erro;
      if (!trans_q.escrita) begin
        if (trans_q.dados) rdata_d = dado_lido;
        else               bdado_d = dado_lido;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      cont_q       <= '0;
      prio_dados_q <= 1'b1;
      trans_q      <= '0;
      mem_end_q    <= '0;
      mem_wd_q     <= '0;
      bdado_q      <= '0;
      rdata_q      <= '0;
      leit_q       <= 1'b0;
      esc_q        <= 1'b0;
      back_q       <= 1'b0;
      dack_q       <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      cont_q       <= cont_d;
      prio_dados_q <= prio_dados_d;
      trans_q      <= trans_d;
      mem_end_q    <= mem_end_d;
      mem_wd_q     <= mem_wd_d;
      bdado_q      <= bdado_d;
      rdata_q      <= rdata_d;
      leit_q       <= leit_d;
      esc_q        <= esc_d;
      back_q       <= back_d;
      dack_q       <= dack_d;
      erro_q       <= erro_d;
    end
  end

  assign bus.busca_ack        = back_q;
  assign bus.busca_dado       = bdado_q;
  assign bus.dados_ack        = dack_q;
  assign bus.dados_rdata      = rdata_q;
  assign bus.erro_endereco    = erro_q;
  assign bus.mem_endereco     = mem_end_q;
  assign bus.mem_dado_escrita = mem_wd_q;
  assign bus.mem_leitura      = leit_q;
  assign bus.mem_escrita      = esc_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: memoria model, transaction-level timing/data scoreboard,
// directed scenarios and two randomized concurrent requesters.
module tb_arbitro_memoria;
  localparam int C = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  arbitro_memoria_if #(.LARGURA(32)) bus ();

  arbitro_memoria #(.LARGURA(32), .PALAVRAS(1024), .CICLOS_ACESSO(C)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit end_erro(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
  endfunction

  // memoria: combinational read, write on the rising edge of the write strobe
  logic [31:0] ram [1024];
  logic        esc_ant = 1'b0;
  assign bus.mem_instrucao = ram[bus.mem_endereco[9:0]];
  always @(posedge clock) begin
    if (bus.mem_escrita && !esc_ant) ram[bus.mem_endereco[9:0]] = bus.mem_dado_escrita;
    esc_ant = bus.mem_escrita;
  end

  // reference: one outstanding access, fixed latencies, alternation on contention
  logic [31:0] ref_mem [1024];
  int          cyc = 0, free_at = 0, p_cyc = 0, run = 0, rises_l = 0, rises_e = 0;
  bit          pv = 0, p_d = 0, p_w = 0, p_e = 0, m_prio_d = 1, pl = 0, pe = 0;
  logic [31:0] p_idx = 0, p_wd = 0, exp_bd = 0, exp_dr = 0, ult_end = 0;
  bit          ordem [$];

  always @(negedge clock) begin : monitor
    logic [31:0] a;
    bit fim_b, fim_d;
    int lat;
    if (reset) begin
      pv = 0; m_prio_d = 1; free_at = cyc + 1; exp_bd = 0; exp_dr = 0;
      run = 0; pl = 0; pe = 0;
    end else begin
      fim_b = pv && (p_cyc == cyc) && !p_d;
      fim_d = pv && (p_cyc == cyc) && p_d;
      chk("busca_ack", bus.busca_ack, fim_b);
      chk("dados_ack", bus.dados_ack, fim_d);
      chk("erro_endereco", bus.erro_endereco, (fim_b | fim_d) & p_e);
      if (fim_b | fim_d) begin
        if (p_e) begin
          if (!p_w) begin
            if (p_d) exp_dr = 0; else exp_bd = 0;
          end
        end else if (p_w) ref_mem[p_idx[9:0]] = p_wd;
        else if (p_d) exp_dr = ref_mem[p_idx[9:0]];
        else exp_bd = ref_mem[p_idx[9:0]];
        chk("busca_dado", bus.busca_dado, exp_bd);
        chk("dados_rdata", bus.dados_rdata, exp_dr);
        ordem.push_back(p_d);
        pv = 0;
      end

      chk("exclusao", bus.mem_leitura & bus.mem_escrita, 0);
      chk("lacuna", (bus.mem_leitura & pe) | (bus.mem_escrita & pl), 0);
      if (bus.mem_leitura | bus.mem_escrita) begin
        run++;
        if (bus.mem_leitura && !pl) rises_l++;
        if (bus.mem_escrita && !pe) rises_e++;
        ult_end = bus.mem_endereco;
        chk("strobe_sem_acesso", pv && !p_e, 1);
        chk("mem_endereco", bus.mem_endereco, p_idx);
        chk("strobe_tipo", bus.mem_escrita, p_w);
        if (p_w) chk("mem_dado_escrita", bus.mem_dado_escrita, p_wd);
      end else if (pl | pe) begin
        chk("duracao_strobe", run, C);
        run = 0;
      end
      pl = bus.mem_leitura;
      pe = bus.mem_escrita;

      if (!pv && cyc >= free_at && (bus.busca_req || bus.dados_req)) begin
        p_d      = bus.dados_req && (!bus.busca_req || m_prio_d);
        m_prio_d = !p_d;
        a        = p_d ? bus.dados_endereco : bus.busca_endereco;
        p_w      = p_d && bus.dados_escrita;
        p_wd     = bus.dados_wdata;
        p_e      = end_erro(a);
        p_idx    = a >> 2;
        lat      = p_e ? 2 : C + 2;
        p_cyc    = cyc + lat;
        free_at  = cyc + lat + 1;
        pv       = 1;
      end
    end
    cyc++;
  end

  // caller sits just after a rising edge; returns just after the edge following ack, req still high
  task automatic requisitar(input bit lado_d, input bit escr, input logic [31:0] a,
                            input logic [31:0] wd, output int lat, output logic err);
    int n;
    bit ok;
    if (lado_d) begin
      bus.dados_req = 1; bus.dados_escrita = escr; bus.dados_endereco = a; bus.dados_wdata = wd;
    end else begin
      bus.busca_req = 1; bus.busca_endereco = a;
    end
    n = 0; ok = 0; err = 0;
    while (!ok && n < 64) begin
      @(negedge clock);
      n++;
      if (lado_d ? bus.dados_ack : bus.busca_ack) begin
        ok = 1; err = bus.erro_endereco;
      end
    end
    chk("prazo_ack", ok, 1);
    lat = n - 1;
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] end_aleat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return ($urandom_range(0, 1023) << 2) | $urandom_range(1, 3);
    if (r == 1) return 32'h1000 + ($urandom_range(0, 4095) << 2);
    if ($urandom_range(0, 1) == 1) return $urandom_range(0, 7) << 2;
    return $urandom_range(1016, 1023) << 2;
  endfunction

  int          lat, rl0, re0;
  logic        err;
  logic [31:0] ini;
  bit          e;

  initial begin
    bus.busca_req = 0; bus.busca_endereco = 0;
    bus.dados_req = 0; bus.dados_escrita = 0; bus.dados_endereco = 0; bus.dados_wdata = 0;
    for (int i = 0; i < 1024; i++) begin
      ini = $urandom;
      ram[i] = ini; ref_mem[i] = ini;
    end
    ram[4] = 32'h2002_0005; ref_mem[4] = 32'h2002_0005;
    ram[0] = 32'h0000_0013; ref_mem[0] = 32'h0000_0013;

    @(negedge clock);
    chk("rst_busca_ack", bus.busca_ack, 0);
    chk("rst_dados_ack", bus.dados_ack, 0);
    chk("rst_erro", bus.erro_endereco, 0);
    chk("rst_mem_endereco", bus.mem_endereco, 0);
    chk("rst_mem_dado_escrita", bus.mem_dado_escrita, 0);
    chk("rst_strobes", {bus.mem_leitura, bus.mem_escrita}, 0);
    chk("rst_busca_dado", bus.busca_dado, 0);
    chk("rst_dados_rdata", bus.dados_rdata, 0);
    @(posedge clock); #1 reset = 0;
    @(posedge clock); #1;

    // fetch word 4
    rl0 = rises_l; re0 = rises_e;
    requisitar(0, 0, 32'h10, 0, lat, err);
    bus.busca_req = 0;
    chk("t1_latencia", lat, C + 2);
    chk("t1_busca_dado", bus.busca_dado, 32'h2002_0005);
    chk("t1_mem_endereco", ult_end, 4);
    chk("t1_pulsos_leitura", rises_l - rl0, 1);
    chk("t1_pulsos_escrita", rises_e - re0, 0);
    @(posedge clock); #1;

    // store to last valid word then read it back
    rl0 = rises_l; re0 = rises_e;
    requisitar(1, 1, 32'hFFC, 32'hDEAD_BEEF, lat, err);
    bus.dados_req = 0;
    chk("t2_erro_escrita", err, 0);
    chk("t2_mem_endereco", ult_end, 1023);
    chk("t2_pulsos_escrita", rises_e - re0, 1);
    @(posedge clock); #1;
    requisitar(1, 0, 32'hFFC, 0, lat, err);
    bus.dados_req = 0;
    chk("t2_erro_leitura", err, 0);
    chk("t2_dados_rdata", bus.dados_rdata, 32'hDEAD_BEEF);
    @(posedge clock); #1;

    // out of range, then misaligned
    rl0 = rises_l; re0 = rises_e;
    requisitar(1, 0, 32'h1000, 0, lat, err);
    bus.dados_req = 0;
    chk("t3_erro_fora", err, 1);
    chk("t3_rdata_fora", bus.dados_rdata, 0);
    @(posedge clock); #1;
    requisitar(1, 0, 32'h6, 0, lat, err);
    bus.dados_req = 0;
    chk("t3_erro_desalinhado", err, 1);
    chk("t3_rdata_desalinhado", bus.dados_rdata, 0);
    chk("t3_sem_strobe", (rises_l - rl0) + (rises_e - re0), 0);
    @(posedge clock); #1;

    // address 0 is valid
    requisitar(0, 0, 32'h0, 0, lat, err);
    bus.busca_req = 0;
    chk("t4_end_zero_erro", err, 0);
    chk("t4_end_zero_dado", bus.busca_dado, 32'h0000_0013);
    @(posedge clock); #1;

    // both requesters continuously pending
    ordem.delete();
    e = m_prio_d;
    fork
      begin
        int l; logic r;
        requisitar(1, 0, 32'h20, 0, l, r);
        requisitar(1, 0, 32'h24, 0, l, r);
        bus.dados_req = 0;
      end
      begin
        int l; logic r;
        requisitar(0, 0, 32'h28, 0, l, r);
        requisitar(0, 0, 32'h2C, 0, l, r);
        bus.busca_req = 0;
      end
    join
    chk("t4_ordem_qtd", ordem.size(), 4);
    chk("t4_primeiro_dados", e, 1);
    for (int i = 0; i < 4 && i < ordem.size(); i++) begin
      chk("t4_ordem", ordem[i], e);
      e = !e;
    end
    @(posedge clock); #1;

    // reset during the strobe of a load
    bus.dados_req = 1; bus.dados_escrita = 0; bus.dados_endereco = 32'h8;
    @(posedge clock);
    @(posedge clock);
    #3 chk("t5_leitura_ativa", bus.mem_leitura, 1);
    reset = 1;
    #1;
    chk("t5_strobes", {bus.mem_leitura, bus.mem_escrita}, 0);
    chk("t5_acks", {bus.busca_ack, bus.dados_ack, bus.erro_endereco}, 0);
    chk("t5_mem_endereco", bus.mem_endereco, 0);
    chk("t5_dados_rdata", bus.dados_rdata, 0);
    chk("t5_busca_dado", bus.busca_dado, 0);
    bus.dados_req = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(posedge clock); #1;
    requisitar(0, 0, 32'h10, 0, lat, err);
    bus.busca_req = 0;
    chk("t5_latencia", lat, C + 2);
    chk("t5_busca_dado", bus.busca_dado, 32'h2002_0005);
    @(posedge clock); #1;

    // randomized concurrent traffic
    fork
      for (int i = 0; i < 40; i++) begin
        int l, g; logic r;
        requisitar(1, 1'($urandom_range(0, 1)), end_aleat(), $urandom, l, r);
        g = $urandom_range(0, 3);
        if (g != 0) begin
          bus.dados_req = 0;
          repeat (g) begin @(posedge clock); #1; end
        end
      end
      for (int i = 0; i < 40; i++) begin
        int l, g; logic r;
        requisitar(0, 0, end_aleat(), 0, l, r);
        g = $urandom_range(0, 3);
        if (g != 0) begin
          bus.busca_req = 0;
          repeat (g) begin @(posedge clock); #1; end
        end
      end
    join
    bus.dados_req = 0;
    bus.busca_req = 0;
    repeat (20) @(negedge clock);
    chk("fila_vazia", pv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1);
  end

endmodule
